// File: rtl/timer_counter_pkg.sv
// -----------------------------------------------------------------------------
// timer_counter_pkg
//
// Shared definitions for the memory-mapped timer/counter:
//   - FSM state encoding
//   - register word offsets on the 2-bit address bus
//   - CTRL register bit positions
//   - CTRL.Mode encodings
//
// No ports; imported by timer_counter with `import timer_counter_pkg::*;`.
// The optional auto-reload feature (macro TIMER_AUTO_RELOAD_EN) is resolved in
// timer_counter itself; nothing in this package depends on it.
// -----------------------------------------------------------------------------
package timer_counter_pkg;

  // Timer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Register word offsets.
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL bit positions.
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // CTRL.Mode encodings. Modes 2 and 3 behave as one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;
  localparam logic [1:0] MODE_RSVD2   = 2'd2;
  localparam logic [1:0] MODE_RSVD3   = 2'd3;

  // Assemble the 32-bit CTRL read value; unused upper bits read as zero.
  function automatic logic [31:0] pack_ctrl(input logic       en,
                                            input logic [1:0] mode,
                                            input logic       im);
    logic [31:0] v;
    v                              = '0;
    v[CTRL_EN_BIT]                 = en;
    v[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
    v[CTRL_IM_BIT]                 = im;
    return v;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// 32-bit programmable down-counting timer with a three-register map and a
// level interrupt output for the coprocessor HWInt vector.
//
// Register map (word offsets on addr):
//   0 CTRL   : [0] Enable, [2:1] Mode, [3] IM (interrupt mask), [31:4] read 0
//   1 PRESET : 32-bit reload value, read/write
//   2 COUNT  : current count, read-only (writes ignored)
//   3        : reserved, reads 0
//
// Ports:
//   clk   in   1  rising-edge clock
//   reset in   1  synchronous, active-high; clears all registers, FSM to IDLE
//   addr  in   2  register word offset
//   we    in   1  write enable for the addressed register
//   din   in  32  write data
//   dout  out 32  combinational read data of the addressed register
//   irq   out  1  IM & irq_flag, held until software writes CTRL or PRESET
//
// Configuration:
//   TIMER_AUTO_RELOAD_EN  defined   -> Mode 1 reloads and restarts after expiry
//                         undefined -> Mode 1 behaves as one-shot; the Mode
//                                      field is still stored and read back.
//
// Timing: with PRESET=N (N>=1) and a CTRL write setting Enable, irq rises
// N+2 edges after the write edge (IDLE->LOAD, LOAD->CNT, N-1 decrements,
// expiry). PRESET=0 behaves as PRESET=1.
// -----------------------------------------------------------------------------
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

`ifdef TIMER_AUTO_RELOAD_EN
  localparam logic AUTO_RELOAD = 1'b1;
`else
  localparam logic AUTO_RELOAD = 1'b0;
`endif

  // Architectural state.
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;
  state_e      state_q;

  // Bus write decode.
  logic wr_ctrl;
  logic wr_preset;
  logic wr_disable;
  logic reload_mode;

  assign wr_ctrl     = we && (addr == ADDR_CTRL);
  assign wr_preset   = we && (addr == ADDR_PRESET);
  assign wr_disable  = wr_ctrl && !din[CTRL_EN_BIT];
  assign reload_mode = AUTO_RELOAD && (mode_q == MODE_RELOAD);

  // FSM and register file in one process. The FSM actions are evaluated
  // first and the software write block afterwards, so a bus write to CTRL
  // or PRESET overrides any FSM update of the same bits on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      mode_q     <= MODE_ONESHOT;
      im_q       <= 1'b0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_q) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          count_q    <= preset_q;
          irq_flag_q <= 1'b0;
          state_q    <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_q) begin
            state_q <= ST_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            // Covers COUNT==0 too, so PRESET=0 never wraps to all-ones.
            count_q    <= '0;
            irq_flag_q <= 1'b1;
            state_q    <= ST_INT;
          end
        end
        ST_INT: begin
          if (reload_mode) begin
            // Drop the flag and go through IDLE so the next pass reloads.
            irq_flag_q <= 1'b0;
          end else begin
            // One-shot: disarm; flag stays until software touches CTRL/PRESET.
            en_q <= 1'b0;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (wr_ctrl) begin
        en_q       <= din[CTRL_EN_BIT];
        mode_q     <= din[CTRL_MODE_MSB:CTRL_MODE_LSB];
        im_q       <= din[CTRL_IM_BIT];
        irq_flag_q <= 1'b0;
      end

      // Disabling stops the counter immediately: COUNT is frozen at its
      // current value and the FSM returns to IDLE regardless of state.
      if (wr_disable) begin
        count_q <= count_q;
        state_q <= ST_IDLE;
      end

      // PRESET only reaches COUNT through LOAD, so a write mid-count does
      // not disturb the running countdown.
      if (wr_preset) begin
        preset_q   <= din;
        irq_flag_q <= 1'b0;
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = pack_ctrl(en_q, mode_q, im_q);
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      ADDR_RSVD:   dout = '0;
      default:     dout = '0;
    endcase
  end

  assign irq = im_q & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//
// Self-checking bench for timer_counter: directed scenarios followed by
// randomized bus traffic, all compared against a behavioural model that
// derives COUNT arithmetically from the value captured at load time.
// -----------------------------------------------------------------------------
module tb_timer_counter;

`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  // m_run: 0 idle, 1 load pending, 2 counting, 3 expired (one edge of action).
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  int          m_run;
  longint      m_e;    // decrements since load
  longint      m_eff;  // effective load value (PRESET 0 counts as 1)

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_reg(input int a);
    case (a)
      0:       return {28'b0, m_im, m_mode, m_en};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_count = 0; m_run = 0; m_e = 0; m_eff = 0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic [1:0] a,
                            input logic [31:0] d);
    logic        n_en, n_im, n_flag;
    logic [1:0]  n_mode;
    logic [31:0] n_preset, n_count;
    int          n_run;
    longint      n_e, n_eff;
    if (r) begin
      model_reset();
      return;
    end
    n_en = m_en; n_im = m_im; n_flag = m_flag; n_mode = m_mode;
    n_preset = m_preset; n_count = m_count; n_run = m_run;
    n_e = m_e; n_eff = m_eff;
    case (m_run)
      0: if (m_en) n_run = 1;
      1: begin
        n_count = m_preset;
        n_flag  = 0;
        n_eff   = (m_preset == 0) ? 64'd1 : longint'(m_preset);
        n_e     = 0;
        n_run   = 2;
      end
      2: begin
        if (!m_en) n_run = 0;
        else if (m_e + 1 >= m_eff) begin
          n_count = 0; n_flag = 1; n_run = 3;
        end else begin
          n_e     = m_e + 1;
          n_count = 32'(m_eff - n_e);
        end
      end
      default: begin
        if (RELOAD_EN && m_mode == 2'd1) n_flag = 0;
        else n_en = 0;
        n_run = 0;
      end
    endcase
    if (w && a == 2'd0) begin
      n_en = d[0]; n_mode = d[2:1]; n_im = d[3]; n_flag = 0;
      if (!d[0]) begin
        n_run = 0; n_count = m_count;
      end
    end
    if (w && a == 2'd1) begin
      n_preset = d; n_flag = 0;
    end
    m_en = n_en; m_im = n_im; m_flag = n_flag; m_mode = n_mode;
    m_preset = n_preset; m_count = n_count; m_run = n_run;
    m_e = n_e; m_eff = n_eff;
  endtask

  // One clock: drive at negedge, advance model at posedge, then compare irq
  // and every register readback shortly after the edge.
  task automatic cycle(input logic r, input logic w, input logic [1:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    reset = r; we = w; addr = a; din = d;
    @(posedge clk);
    model_step(r, w, a, d);
    #1;
    reset = 0; we = 0;
    check_eq("irq", {31'b0, irq}, {31'b0, m_im & m_flag});
    for (int i = 0; i < 4; i++) begin
      addr = i[1:0];
      #1;
      check_eq($sformatf("reg%0d", i), dout, exp_reg(i));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 2'd2, 32'h0);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          rises[$];
    logic        prev_irq;
    int          width;
    int          maxw;
    reset = 1; we = 0; addr = 0; din = 0;
    model_reset();

    // Reset state.
    cycle(1, 0, 2'd0, 32'h0);
    cycle(1, 1, 2'd1, 32'hDEAD_BEEF);   // reset beats a concurrent write
    read_reg(2'd0, v); check_eq("rst_ctrl", v, 32'h0);
    read_reg(2'd1, v); check_eq("rst_preset", v, 32'h0);
    read_reg(2'd2, v); check_eq("rst_count", v, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);

    // One-shot, PRESET=5: irq 7 edges after the CTRL write, Enable self-clears.
    cycle(0, 1, 2'd1, 32'd5);
    cycle(0, 1, 2'd0, 32'h9);
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 2'd2, 32'h0);
      check_eq($sformatf("oneshot_irq_t%0d", i), {31'b0, irq}, (i == 7) ? 32'd1 : 32'd0);
    end
    idle_cycles(3);
    check_eq("oneshot_irq_held", {31'b0, irq}, 32'd1);
    read_reg(2'd0, v); check_eq("oneshot_en_cleared", {31'b0, v[0]}, 32'd0);

    // Writing CTRL=0 drops irq on the next edge.
    cycle(0, 1, 2'd0, 32'h0);
    check_eq("ctrl_clear_irq", {31'b0, irq}, 32'd0);
    idle_cycles(2);
    read_reg(2'd0, v); check_eq("ctrl_clear_ctrl", v, 32'h0);

    // PRESET=0 behaves as PRESET=1; COUNT never wraps.
    cycle(0, 1, 2'd1, 32'd0);
    cycle(0, 1, 2'd0, 32'h9);
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 0, 2'd2, 32'h0);
      read_reg(2'd2, v);
      check_eq($sformatf("p0_count_t%0d", i), {31'b0, v == 32'hFFFF_FFFF}, 32'd0);
      if (i == 3) check_eq("p0_irq_rise", {31'b0, irq}, 32'd1);
    end
    cycle(0, 1, 2'd0, 32'h0);

    // Reset mid-count with a concurrent write.
    cycle(0, 1, 2'd1, 32'd6);
    cycle(0, 1, 2'd0, 32'h9);
    for (int k = 0; k < 20 && m_count != 32'd2; k++) cycle(0, 0, 2'd2, 32'h0);
    read_reg(2'd2, v); check_eq("midcount_is2", v, 32'd2);
    cycle(1, 1, 2'd0, 32'hF);
    read_reg(2'd0, v); check_eq("midrst_ctrl", v, 32'h0);
    read_reg(2'd1, v); check_eq("midrst_preset", v, 32'h0);
    read_reg(2'd2, v); check_eq("midrst_count", v, 32'h0);
    check_eq("midrst_irq", {31'b0, irq}, 32'd0);

    // Masked expiry, then unmasking via a CTRL write clears the flag.
    cycle(0, 1, 2'd1, 32'd2);
    cycle(0, 1, 2'd0, 32'h1);
    idle_cycles(6);
    check_eq("masked_irq", {31'b0, irq}, 32'd0);
    cycle(0, 1, 2'd0, 32'h8);
    check_eq("unmask_irq", {31'b0, irq}, 32'd0);
    idle_cycles(2);
    check_eq("unmask_irq_later", {31'b0, irq}, 32'd0);

    // Mode 1 with PRESET=3: single-cycle pulses every 6 edges when auto-reload
    // is built in; otherwise a held one-shot interrupt.
    cycle(0, 1, 2'd1, 32'd3);
    cycle(0, 1, 2'd0, 32'hB);
    prev_irq = 0; width = 0; maxw = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 2'd2, 32'h0);
      if (irq && !prev_irq) rises.push_back(i);
      width = irq ? width + 1 : 0;
      if (width > maxw) maxw = width;
      prev_irq = irq;
    end
    if (RELOAD_EN) begin
      check_eq("reload_pulses", {31'b0, rises.size() >= 5}, 32'd1);
      check_eq("reload_width", maxw, 32'd1);
      for (int j = 1; j < rises.size(); j++)
        check_eq($sformatf("reload_period%0d", j), rises[j] - rises[j-1], 32'd6);
    end else begin
      check_eq("mode1_oneshot_rises", rises.size(), 32'd1);
      check_eq("mode1_oneshot_held", {31'b0, irq}, 32'd1);
    end
    cycle(0, 1, 2'd0, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        r, w;
      logic [1:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 15));
      cycle(r, w, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have no parameters; the register map and widths are fixed.
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  2  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3 reserved.
REQ-005 we  input  1  write enable for the addressed register.
REQ-006 din  input  32  write data.
REQ-007 dout  output  32  combinational read data of the addressed register; reads 0 at addr 3.
REQ-008 irq  output  1  interrupt request, wired to one bit of the coprocessor HWInt vector.

Function
REQ-009 CTRL[0]=Enable, CTRL[2:1]=Mode, CTRL[3]=IM (interrupt mask); CTRL[31:4] SHALL read as 0.
REQ-010 PRESET SHALL be 32-bit read/write; COUNT SHALL be read-only, and writes to it SHALL be ignored.
REQ-011 The FSM SHALL have the states IDLE, LOAD, CNT, and INT.
REQ-012 IDLE: if Enable=1, next state LOAD; otherwise remain in IDLE.
REQ-013 LOAD: COUNT<=PRESET, clear irq_flag, next state CNT.
REQ-014 CNT with Enable=0: hold COUNT, next state IDLE.
REQ-015 CNT with Enable=1 and COUNT>1: COUNT<=COUNT-1.
REQ-016 CNT with Enable=1 and COUNT<=1: COUNT<=0, irq_flag<=1, next state INT.
REQ-017 INT, Mode 0 (one-shot): clear Enable, next state IDLE; irq_flag held until CTRL or PRESET is written.
REQ-018 INT, Mode 1 (auto-reload): irq_flag<=0, next state IDLE, so the timer reloads and restarts while Enable=1.
REQ-019 Modes 2 and 3 SHALL behave as Mode 0.
REQ-020 irq SHALL equal IM & irq_flag, combinationally.
REQ-021 irq SHALL remain asserted until cleared by software, so the coprocessor latches it only when IE=1 and EXL=0.
REQ-022 When PRESET=N>=1 in Mode 0, irq SHALL rise N+2 cycles after the cycle in which Enable is written to 1.
REQ-023 When PRESET=0 or PRESET=1, the block SHALL behave as PRESET=1, with no underflow to 0xFFFFFFFF.
REQ-024 A write to CTRL or PRESET SHALL clear irq_flag in the same edge.
REQ-025 A simultaneous write and FSM update of CTRL SHALL give the software write priority.
REQ-026 A write of Enable=0 SHALL stop counting and return the FSM to IDLE next edge from any state.
REQ-027 Writing PRESET during CNT SHALL NOT change COUNT until the next LOAD.

Reset
REQ-028 Reset SHALL clear CTRL, PRESET, COUNT, and irq_flag to 0 and put the FSM in IDLE; irq and dout (at addr 0..2) SHALL read 0.
REQ-029 Reset SHALL override any concurrent write, including mid-count.

Configuration
REQ-030 With macro TIMER_AUTO_RELOAD_EN defined, Mode 1 SHALL behave per REQ-018.
REQ-031 With TIMER_AUTO_RELOAD_EN undefined, Mode 1 SHALL behave as Mode 0.
REQ-032 With TIMER_AUTO_RELOAD_EN undefined, CTRL[2:1] SHALL read as written.

Structure
REQ-033 The shared package SHALL hold the FSM state enum, register offsets, CTRL bit positions, and mode encodings.
REQ-034 The block SHALL be a single module with no sub-module.
REQ-035 The bridge SHALL decode the address window and drive addr, we, and din.

Verification
REQ-036 Write PRESET=5, then CTRL=0x9 (Enable, IM, Mode 0) -> irq rises 7 cycles after the CTRL write, stays high, and Enable reads 0.
REQ-037 With the macro defined: PRESET=3, CTRL=0xB (Mode 1) -> irq pulses high for 1 cycle, repeating with a fixed period of 6 cycles.
REQ-038 PRESET=0, CTRL=0x9 -> COUNT never reads 0xFFFFFFFF, and irq rises.
REQ-039 irq high in Mode 0 -> CTRL write 0x0 -> irq low the next cycle, and FSM in IDLE.
REQ-040 Assert reset mid-count (COUNT=2) -> all registers read 0 next cycle, and irq=0.
REQ-041 Mode 0 with IM=0 expiring -> irq stays 0; then write CTRL IM=1 -> irq still 0, because the write clears irq_flag.
